// File: rtl/sonar_pkg.sv
// Shared sonar constants and the per-angle record type used by the beam sweep scheduler.
package sonar_pkg;

   localparam int ANGLE_WIDTH   = 8;
   localparam int RANGE_WIDTH   = 16;
   localparam int ANGLE_MIN     = -30;
   localparam int ANGLE_MAX     = 30;
   localparam int ANGLE_STEP    = 10;
   localparam int DWELL_PERIODS = 2;

   // One record per completed dwell; the field widths follow the package widths above.
   typedef struct packed {
      logic signed [ANGLE_WIDTH-1:0] angle;
      logic [RANGE_WIDTH-1:0]        range;
      logic                          hit;
   } beam_rec_t;

endpackage

// File: rtl/sweep_angle_stepper.sv
// Beam angle register with step / wrap / hold behaviour.
// A step request is taken in the cycle a dwell closes; the angle itself moves at the end of
// the following (commit) cycle, and the registered wrap flag is high during that commit cycle.
module sweep_angle_stepper #(
   parameter int ANGLE_WIDTH = 8,
   parameter int ANGLE_MIN   = -30,
   parameter int ANGLE_MAX   = 30,
   parameter int ANGLE_STEP  = 10
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          step_in,
   input  logic                          hold_in,
   output logic signed [ANGLE_WIDTH-1:0] angle_out,
   output logic                          wrap_now_out,
   output logic                          wrap_out
);

   localparam logic signed [ANGLE_WIDTH-1:0] A_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
   localparam logic signed [ANGLE_WIDTH-1:0] A_MAX  = ANGLE_WIDTH'(ANGLE_MAX);
   localparam logic signed [ANGLE_WIDTH-1:0] A_STEP = ANGLE_WIDTH'(ANGLE_STEP);

   logic signed [ANGLE_WIDTH-1:0] angle_reg;
   logic                          pend_reg;
   logic                          hold_pend_reg;
   logic                          wrap_reg;

   // The step requested right now ends the sweep (not held, sitting on the last angle).
   assign wrap_now_out = step_in && !hold_in && (angle_reg == A_MAX);
   assign angle_out    = angle_reg;
   assign wrap_out     = wrap_reg;

   // Latch the step decision at dwell close, then apply it one cycle later.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         angle_reg     <= A_MIN;
         pend_reg      <= 1'b0;
         hold_pend_reg <= 1'b0;
         wrap_reg      <= 1'b0;
      end else begin
         pend_reg      <= step_in;
         hold_pend_reg <= hold_in;
         wrap_reg      <= wrap_now_out;
         if (pend_reg && !hold_pend_reg) begin
            angle_reg <= wrap_reg ? A_MIN : angle_reg + A_STEP;
         end
      end
   end

endmodule

// File: rtl/beam_sweep_scheduler.sv
// Steps the sonar beam across a fan of angles, dwells a fixed number of burst periods at each,
// keeps the nearest echo per dwell and the nearest hit per complete sweep.
module beam_sweep_scheduler #(
   parameter int ANGLE_WIDTH   = sonar_pkg::ANGLE_WIDTH,
   parameter int ANGLE_MIN     = sonar_pkg::ANGLE_MIN,
   parameter int ANGLE_MAX     = sonar_pkg::ANGLE_MAX,
   parameter int ANGLE_STEP    = sonar_pkg::ANGLE_STEP,
   parameter int RANGE_WIDTH   = sonar_pkg::RANGE_WIDTH,
   parameter int DWELL_PERIODS = sonar_pkg::DWELL_PERIODS
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          burst_start_in,
   input  logic                          tof_valid_in,
   input  logic [RANGE_WIDTH-1:0]        range_in,
   input  logic                          hold_in,
   output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
   output logic                          rec_valid_out,
   output logic signed [ANGLE_WIDTH-1:0] rec_angle_out,
   output logic [RANGE_WIDTH-1:0]        rec_range_out,
   output logic                          rec_hit_out,
   output logic                          sweep_done_out,
   output logic                          nearest_valid_out,
   output logic signed [ANGLE_WIDTH-1:0] nearest_angle_out,
   output logic [RANGE_WIDTH-1:0]        nearest_range_out
);

   import sonar_pkg::*;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DWELL  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   localparam int               CNT_W    = $clog2(DWELL_PERIODS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_PERIODS - 1);

   logic [1:0]                    state_reg;
   logic [CNT_W-1:0]              cnt_reg;
   logic                          got_tof_reg;
   logic                          hit_reg;
   logic [RANGE_WIDTH-1:0]        dwell_min_reg;
   logic                          trk_valid_reg;
   logic signed [ANGLE_WIDTH-1:0] trk_angle_reg;
   logic [RANGE_WIDTH-1:0]        trk_range_reg;
   beam_rec_t                     rec_reg;
   logic                          rec_valid_reg;
   logic                          nearest_valid_reg;
   logic signed [ANGLE_WIDTH-1:0] nearest_angle_reg;
   logic [RANGE_WIDTH-1:0]        nearest_range_reg;

   logic signed [ANGLE_WIDTH-1:0] angle;
   logic                          wrap_now;
   logic                          tof_take;
   logic                          eff_hit;
   logic [RANGE_WIDTH-1:0]        eff_min;
   logic                          close;
   logic                          better;
   logic                          best_valid;
   logic signed [ANGLE_WIDTH-1:0] best_angle;
   logic [RANGE_WIDTH-1:0]        best_range;

   sweep_angle_stepper #(
      .ANGLE_WIDTH (ANGLE_WIDTH),
      .ANGLE_MIN   (ANGLE_MIN),
      .ANGLE_MAX   (ANGLE_MAX),
      .ANGLE_STEP  (ANGLE_STEP)
   ) u_stepper (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .step_in      (close),
      .hold_in      (hold_in),
      .angle_out    (angle),
      .wrap_now_out (wrap_now),
      .wrap_out     (sweep_done_out)
   );

   // Dwell bookkeeping including a tof that coincides with the closing burst, plus the
   // sweep tracker candidate (strict less-than so ties keep the earlier angle).
   always_comb begin
      tof_take   = (state_reg == ST_DWELL) && tof_valid_in && !got_tof_reg;
      eff_hit    = hit_reg | tof_take;
      eff_min    = (tof_take && (!hit_reg || range_in < dwell_min_reg)) ? range_in : dwell_min_reg;
      close      = (state_reg == ST_DWELL) && burst_start_in && (cnt_reg == CNT_LAST);
      better     = eff_hit && (!trk_valid_reg || eff_min < trk_range_reg);
      best_valid = trk_valid_reg | eff_hit;
      best_angle = better ? angle : trk_angle_reg;
      best_range = better ? eff_min : trk_range_reg;
   end

   // Control FSM, dwell accumulation, record output and sweep tracking.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg         <= ST_IDLE;
         cnt_reg           <= '0;
         got_tof_reg       <= 1'b0;
         hit_reg           <= 1'b0;
         dwell_min_reg     <= '0;
         trk_valid_reg     <= 1'b0;
         trk_angle_reg     <= '0;
         trk_range_reg     <= '0;
         rec_reg           <= '0;
         rec_valid_reg     <= 1'b0;
         nearest_valid_reg <= 1'b0;
         nearest_angle_reg <= '0;
         nearest_range_reg <= '0;
      end else begin
         rec_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (burst_start_in) begin
                  state_reg   <= ST_DWELL;
                  cnt_reg     <= '0;
                  got_tof_reg <= 1'b0;
                  hit_reg     <= 1'b0;
               end
            end
            ST_DWELL: begin
               if (close) begin
                  state_reg     <= ST_COMMIT;
                  rec_reg.angle <= angle;
                  rec_reg.range <= eff_hit ? eff_min : '1;
                  rec_reg.hit   <= eff_hit;
                  rec_valid_reg <= 1'b1;
                  cnt_reg       <= '0;
                  got_tof_reg   <= 1'b0;
                  hit_reg       <= 1'b0;
                  dwell_min_reg <= '0;
                  if (wrap_now) begin
                     nearest_valid_reg <= best_valid;
                     nearest_angle_reg <= best_valid ? best_angle : '0;
                     nearest_range_reg <= best_valid ? best_range : '0;
                     trk_valid_reg     <= 1'b0;
                     trk_angle_reg     <= '0;
                     trk_range_reg     <= '0;
                  end else begin
                     trk_valid_reg <= best_valid;
                     trk_angle_reg <= best_angle;
                     trk_range_reg <= best_range;
                  end
               end else begin
                  hit_reg       <= eff_hit;
                  dwell_min_reg <= eff_min;
                  if (burst_start_in) begin
                     cnt_reg     <= cnt_reg + 1'b1;
                     got_tof_reg <= 1'b0;
                  end else begin
                     got_tof_reg <= got_tof_reg | tof_valid_in;
                  end
               end
            end
            ST_COMMIT: state_reg <= ST_DWELL;
            default:   state_reg <= ST_IDLE;
         endcase
      end
   end

   assign beam_angle_out    = angle;
   assign rec_valid_out     = rec_valid_reg;
   assign rec_angle_out     = rec_reg.angle;
   assign rec_range_out     = rec_reg.range;
   assign rec_hit_out       = rec_reg.hit;
   assign nearest_valid_out = nearest_valid_reg;
   assign nearest_angle_out = nearest_angle_reg;
   assign nearest_range_out = nearest_range_reg;

endmodule

// File: tb/tb_beam_sweep_scheduler.sv
// Directed bench for beam_sweep_scheduler with default parameters.
module tb_beam_sweep_scheduler;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              burst_start = 1'b0;
   logic              tof_valid = 1'b0;
   logic [15:0]       range_v = '0;
   logic              hold = 1'b0;
   logic signed [7:0] beam_angle;
   logic              rec_valid;
   logic signed [7:0] rec_angle;
   logic [15:0]       rec_range;
   logic              rec_hit;
   logic              sweep_done;
   logic              nearest_valid;
   logic signed [7:0] nearest_angle;
   logic [15:0]       nearest_range;

   int total = 0;
   int bad = 0;
   int sd_cnt = 0;

   typedef struct {
      logic signed [7:0] angle;
      logic [15:0]       range;
      logic              hit;
      logic              sd;
      logic              nv;
      logic signed [7:0] na;
      logic [15:0]       nr;
   } obs_t;

   obs_t rq[$];

   beam_sweep_scheduler dut (
      .clk_in            (clk),
      .rst_in            (rst_n),
      .burst_start_in    (burst_start),
      .tof_valid_in      (tof_valid),
      .range_in          (range_v),
      .hold_in           (hold),
      .beam_angle_out    (beam_angle),
      .rec_valid_out     (rec_valid),
      .rec_angle_out     (rec_angle),
      .rec_range_out     (rec_range),
      .rec_hit_out       (rec_hit),
      .sweep_done_out    (sweep_done),
      .nearest_valid_out (nearest_valid),
      .nearest_angle_out (nearest_angle),
      .nearest_range_out (nearest_range)
   );

   always #5 clk = ~clk;

   // Capture every record (and sweep_done pulses) on the falling edge.
   always @(negedge clk) begin
      if (sweep_done) sd_cnt++;
      if (rec_valid) begin
         obs_t o;
         o.angle = rec_angle; o.range = rec_range; o.hit = rec_hit; o.sd = sweep_done;
         o.nv = nearest_valid; o.na = nearest_angle; o.nr = nearest_range;
         rq.push_back(o);
         $display("rec angle=%0d range=%0d hit=%0b sweep_done=%0b nearest=%0b/%0d/%0d",
                  rec_angle, rec_range, rec_hit, sweep_done, nearest_valid, nearest_angle, nearest_range);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_burst();
      burst_start = 1'b1; clk_wait(1); burst_start = 1'b0;
   endtask

   task automatic do_tof(input logic [15:0] r);
      tof_valid = 1'b1; range_v = r; clk_wait(1); tof_valid = 1'b0;
   endtask

   // Two periods at the current angle; the last burst closes the dwell.
   task automatic do_dwell(input bit t1, input logic [15:0] r1, input bit t2, input logic [15:0] r2);
      if (t1) do_tof(r1);
      clk_wait(1); do_burst(); clk_wait(1);
      if (t2) do_tof(r2);
      clk_wait(1); do_burst(); clk_wait(3);
   endtask

   // Seven dwells; a zero range means no tof in that period.
   task automatic run_sweep(input int ra[7], input int rb[7]);
      for (int i = 0; i < 7; i++)
         do_dwell(ra[i] != 0, 16'(ra[i]), rb[i] != 0, 16'(rb[i]));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clk_wait(3);
      total++; if (beam_angle !== 8'(-30)) begin bad++; $display("FAIL reset_angle got=%0d exp=-30", beam_angle); end
      total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL reset_rec_valid got=%0b exp=0", rec_valid); end
      total++; if ({rec_angle, rec_range, rec_hit} !== 25'd0) begin bad++; $display("FAIL reset_rec got=%0d/%0d/%0b exp=0", rec_angle, rec_range, rec_hit); end
      total++; if (sweep_done !== 1'b0) begin bad++; $display("FAIL reset_sweep_done got=%0b exp=0", sweep_done); end
      total++; if ({nearest_valid, nearest_angle, nearest_range} !== 25'd0) begin bad++; $display("FAIL reset_nearest got=%0b/%0d/%0d exp=0", nearest_valid, nearest_angle, nearest_range); end
      rst_n = 1'b1;
      clk_wait(2);
   endtask

   task automatic test_full_sweep();
      int base = rq.size();
      int s0 = sd_cnt;
      int ra[7] = '{500, 500, 500, 500, 500, 500, 500};
      do_burst(); clk_wait(2);
      run_sweep(ra, ra);
      total++; if (rq.size() - base !== 7) begin bad++; $display("FAIL full_rec_count got=%0d exp=7", rq.size() - base); end
      total++; if (sd_cnt - s0 !== 1) begin bad++; $display("FAIL full_sd_count got=%0d exp=1", sd_cnt - s0); end
      if (rq.size() - base >= 7) begin
         for (int i = 0; i < 7; i++) begin
            total++; if (rq[base+i].angle !== 8'(-30 + 10*i)) begin bad++; $display("FAIL full_angle[%0d] got=%0d exp=%0d", i, rq[base+i].angle, -30 + 10*i); end
            total++; if (rq[base+i].hit !== 1'b1 || rq[base+i].range !== 16'd500) begin bad++; $display("FAIL full_range[%0d] got=%0b/%0d exp=1/500", i, rq[base+i].hit, rq[base+i].range); end
            total++; if (rq[base+i].sd !== (i == 6)) begin bad++; $display("FAIL full_sd[%0d] got=%0b exp=%0b", i, rq[base+i].sd, i == 6); end
         end
         total++; if (rq[base+6].nv !== 1'b1 || rq[base+6].na !== 8'(-30) || rq[base+6].nr !== 16'd500) begin bad++; $display("FAIL full_nearest got=%0b/%0d/%0d exp=1/-30/500", rq[base+6].nv, rq[base+6].na, rq[base+6].nr); end
      end
      total++; if (beam_angle !== 8'(-30)) begin bad++; $display("FAIL full_wrap_angle got=%0d exp=-30", beam_angle); end
   endtask

   task automatic test_min_and_miss();
      int base = rq.size();
      int ra[7] = '{600, 600, 600, 900, 0, 800, 800};
      int rb[7] = '{600, 600, 600, 400, 0, 800, 800};
      run_sweep(ra, rb);
      total++; if (rq.size() - base !== 7) begin bad++; $display("FAIL miss_rec_count got=%0d exp=7", rq.size() - base); end
      if (rq.size() - base >= 7) begin
         total++; if (rq[base+3].angle !== 8'd0 || rq[base+3].hit !== 1'b1 || rq[base+3].range !== 16'd400) begin bad++; $display("FAIL dwell_min got=%0d/%0b/%0d exp=0/1/400", rq[base+3].angle, rq[base+3].hit, rq[base+3].range); end
         total++; if (rq[base+4].angle !== 8'd10 || rq[base+4].hit !== 1'b0 || rq[base+4].range !== 16'hFFFF) begin bad++; $display("FAIL dwell_miss got=%0d/%0b/%0h exp=10/0/ffff", rq[base+4].angle, rq[base+4].hit, rq[base+4].range); end
         total++; if (rq[base+6].sd !== 1'b1 || rq[base+6].nv !== 1'b1 || rq[base+6].na !== 8'd0 || rq[base+6].nr !== 16'd400) begin bad++; $display("FAIL miss_nearest got=%0b %0b/%0d/%0d exp=1 1/0/400", rq[base+6].sd, rq[base+6].nv, rq[base+6].na, rq[base+6].nr); end
      end
   endtask

   task automatic test_nearest_tie();
      int base = rq.size();
      int ra[7] = '{800, 700, 800, 800, 800, 700, 800};
      run_sweep(ra, ra);
      total++; if (rq.size() - base !== 7) begin bad++; $display("FAIL tie_rec_count got=%0d exp=7", rq.size() - base); end
      total++; if (nearest_valid !== 1'b1 || nearest_angle !== 8'(-20) || nearest_range !== 16'd700) begin bad++; $display("FAIL tie_nearest got=%0b/%0d/%0d exp=1/-20/700", nearest_valid, nearest_angle, nearest_range); end
   endtask

   task automatic test_no_hits();
      int base = rq.size();
      int ra[7] = '{0, 0, 0, 0, 0, 0, 0};
      run_sweep(ra, ra);
      total++; if (rq.size() - base !== 7) begin bad++; $display("FAIL nohit_rec_count got=%0d exp=7", rq.size() - base); end
      if (rq.size() - base >= 7) begin
         total++; if (rq[base+6].sd !== 1'b1 || rq[base+6].nv !== 1'b0) begin bad++; $display("FAIL nohit_done got=%0b/%0b exp=1/0", rq[base+6].sd, rq[base+6].nv); end
         total++; if (rq[base+2].hit !== 1'b0 || rq[base+2].range !== 16'hFFFF) begin bad++; $display("FAIL nohit_rec got=%0b/%0h exp=0/ffff", rq[base+2].hit, rq[base+2].range); end
      end
      total++; if (nearest_valid !== 1'b0) begin bad++; $display("FAIL nohit_nearest_valid got=%0b exp=0", nearest_valid); end
   endtask

   task automatic test_hold();
      int base = rq.size();
      int s0 = sd_cnt;
      do_dwell(1, 900, 1, 900);
      do_dwell(1, 900, 1, 900);
      do_tof(950); clk_wait(1); do_burst(); clk_wait(1);
      hold = 1'b1; do_burst(); clk_wait(3); hold = 1'b0;
      total++; if (beam_angle !== 8'(-10)) begin bad++; $display("FAIL hold_angle got=%0d exp=-10", beam_angle); end
      do_dwell(1, 300, 1, 300);
      for (int i = 0; i < 4; i++) do_dwell(1, 900, 1, 900);
      total++; if (rq.size() - base !== 8) begin bad++; $display("FAIL hold_rec_count got=%0d exp=8", rq.size() - base); end
      total++; if (sd_cnt - s0 !== 1) begin bad++; $display("FAIL hold_sd_count got=%0d exp=1", sd_cnt - s0); end
      if (rq.size() - base >= 8) begin
         total++; if (rq[base+2].angle !== 8'(-10) || rq[base+2].sd !== 1'b0 || rq[base+2].range !== 16'd950) begin bad++; $display("FAIL hold_rec got=%0d/%0b/%0d exp=-10/0/950", rq[base+2].angle, rq[base+2].sd, rq[base+2].range); end
         total++; if (rq[base+3].angle !== 8'(-10)) begin bad++; $display("FAIL hold_repeat_angle got=%0d exp=-10", rq[base+3].angle); end
         total++; if (rq[base+7].angle !== 8'd30 || rq[base+7].sd !== 1'b1 || rq[base+7].na !== 8'(-10) || rq[base+7].nr !== 16'd300) begin bad++; $display("FAIL hold_nearest got=%0d/%0b/%0d/%0d exp=30/1/-10/300", rq[base+7].angle, rq[base+7].sd, rq[base+7].na, rq[base+7].nr); end
      end
   endtask

   task automatic test_coincident_and_double();
      int base = rq.size();
      do_tof(700); clk_wait(1); do_burst(); clk_wait(1);
      burst_start = 1'b1; tof_valid = 1'b1; range_v = 16'd200;
      clk_wait(1);
      burst_start = 1'b0; tof_valid = 1'b0;
      clk_wait(3);
      do_tof(300); clk_wait(1); do_tof(100); clk_wait(1); do_burst(); clk_wait(1);
      do_tof(900); clk_wait(1); do_burst(); clk_wait(3);
      total++; if (rq.size() - base !== 2) begin bad++; $display("FAIL coinc_rec_count got=%0d exp=2", rq.size() - base); end
      if (rq.size() - base >= 2) begin
         total++; if (rq[base].angle !== 8'(-30) || rq[base].range !== 16'd200 || rq[base].hit !== 1'b1) begin bad++; $display("FAIL coincident got=%0d/%0d/%0b exp=-30/200/1", rq[base].angle, rq[base].range, rq[base].hit); end
         total++; if (rq[base+1].angle !== 8'(-20) || rq[base+1].range !== 16'd300) begin bad++; $display("FAIL double_tof got=%0d/%0d exp=-20/300", rq[base+1].angle, rq[base+1].range); end
      end
   endtask

   task automatic test_reset_mid_dwell();
      int base;
      int s0;
      for (int i = 0; i < 3; i++) do_dwell(1, 900, 1, 900);
      total++; if (beam_angle !== 8'd20) begin bad++; $display("FAIL pre_reset_angle got=%0d exp=20", beam_angle); end
      base = rq.size();
      s0 = sd_cnt;
      do_tof(250); clk_wait(1); do_burst(); clk_wait(1); do_tof(260);
      #3 rst_n = 1'b0;
      #1;
      total++; if (beam_angle !== 8'(-30)) begin bad++; $display("FAIL async_reset_angle got=%0d exp=-30", beam_angle); end
      total++; if (nearest_valid !== 1'b0 || rec_valid !== 1'b0) begin bad++; $display("FAIL async_reset_outs got=%0b/%0b exp=0/0", nearest_valid, rec_valid); end
      clk_wait(3);
      rst_n = 1'b1;
      clk_wait(2);
      do_tof(10); clk_wait(1);
      do_burst(); clk_wait(1); do_tof(450); clk_wait(1); do_burst(); clk_wait(3);
      total++; if (rq.size() - base !== 0 || sd_cnt - s0 !== 0) begin bad++; $display("FAIL reset_no_record got=%0d/%0d exp=0/0", rq.size() - base, sd_cnt - s0); end
      clk_wait(1); do_burst(); clk_wait(3);
      total++; if (rq.size() - base !== 1) begin bad++; $display("FAIL post_reset_count got=%0d exp=1", rq.size() - base); end
      if (rq.size() - base >= 1) begin
         total++; if (rq[base].angle !== 8'(-30) || rq[base].range !== 16'd450 || rq[base].hit !== 1'b1) begin bad++; $display("FAIL post_reset_rec got=%0d/%0d/%0b exp=-30/450/1", rq[base].angle, rq[base].range, rq[base].hit); end
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_full_sweep();
      test_min_and_miss();
      test_nearest_tie();
      test_no_hits();
      test_hold();
      test_coincident_and_double();
      test_reset_mid_dwell();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/beam_sweep_scheduler.md
BEAM_SWEEP_SCHEDULER -- requirements
Module: beam_sweep_scheduler

Interface
REQ-001 Parameter ANGLE_WIDTH, default 8, signed beam angle width in degrees.
REQ-002 Parameter ANGLE_MIN, default -30, first sweep angle.
REQ-003 Parameter ANGLE_MAX, default 30, last sweep angle; ANGLE_MAX minus ANGLE_MIN SHALL be a multiple of ANGLE_STEP.
REQ-004 Parameter ANGLE_STEP, default 10, angle increment per dwell.
REQ-005 Parameter RANGE_WIDTH, default 16, range word width.
REQ-006 Parameter DWELL_PERIODS, default 2, burst periods spent at each angle (at least 1).
REQ-007 clk_in  input  1  system clock (100 MHz).
REQ-008 rst_in  input  1  reset, asynchronous, active-low.
REQ-009 burst_start_in  input  1  single-cycle pulse marking the start of each burst period.
REQ-010 tof_valid_in  input  1  single-cycle pulse; range_in is valid.
REQ-011 range_in  input  RANGE_WIDTH  measured range for the current period.
REQ-012 hold_in  input  1  freeze the angle at the current dwell.
REQ-013 beam_angle_out  output  ANGLE_WIDTH  signed steering angle for the TX/RX beamformers.
REQ-014 rec_valid_out  output  1  single-cycle pulse; per-angle record is valid.
REQ-015 rec_angle_out / rec_range_out / rec_hit_out  output  ANGLE_WIDTH / RANGE_WIDTH / 1  per-angle record.
REQ-016 sweep_done_out  output  1  single-cycle pulse at the end of each full sweep.
REQ-017 nearest_valid_out / nearest_angle_out / nearest_range_out  output  1 / ANGLE_WIDTH / RANGE_WIDTH  result of the last completed sweep.

Function
REQ-018 FSM states: IDLE, DWELL, COMMIT.
REQ-019 IDLE -> DWELL on the first burst_start_in; no record is emitted.
REQ-020 In DWELL, the block SHALL accept only the first tof_valid_in per period and hold the minimum over the dwell in dwell_min; hit is set if any period in the dwell produced a valid.
REQ-021 A burst_start_in in DWELL SHALL increment the period counter; when the count reaches DWELL_PERIODS, the FSM SHALL enter COMMIT; otherwise it stays in DWELL.
REQ-022 A tof_valid_in coincident with burst_start_in SHALL be credited to the period being closed.
REQ-023 COMMIT lasts one cycle and SHALL pulse rec_valid_out with rec_angle_out = current angle, rec_hit_out = hit, and rec_range_out = dwell_min if hit, else all-ones; it then returns to DWELL with dwell state cleared.
REQ-024 Angle advance at COMMIT: if hold_in = 1, the angle is unchanged and there is no sweep_done; otherwise if the angle equals ANGLE_MAX it wraps to ANGLE_MIN and sweep_done_out pulses in the same cycle as rec_valid_out; otherwise angle + ANGLE_STEP.
REQ-025 beam_angle_out is registered and SHALL change exactly one cycle after COMMIT, i.e. two cycles after the closing burst_start_in.
REQ-026 Sweep tracking: the minimum rec_range_out over hit records is tracked; ties keep the earlier (lower) angle.
REQ-027 At sweep_done, nearest_* SHALL update in the same cycle; nearest_valid_out = 0 if the sweep had no hits. The tracker then clears.
REQ-028 A sweep interrupted by hold SHALL continue accumulating into the same sweep.
REQ-029 Extra tof_valid_in pulses within a period SHALL be ignored; tof_valid_in in IDLE SHALL be ignored.
REQ-030 Range comparison is unsigned; angle arithmetic is signed at ANGLE_WIDTH, with no overflow for legal parameters.

Reset
REQ-031 On rst_in low, asynchronously: state = IDLE; beam_angle_out = ANGLE_MIN; all pulses 0; rec_* = 0; nearest_* = 0; counters and trackers cleared.
REQ-032 Reset mid-dwell SHALL discard the partial dwell and partial sweep; no record is emitted.

Structure
REQ-033 Package sonar_pkg SHALL hold ANGLE_WIDTH, RANGE_WIDTH, the angle limits, and a packed struct for the per-angle record (angle, range, hit).
REQ-034 A single sub-module, sweep_angle_stepper, SHALL hold the angle register, the step/wrap/hold logic, and the wrap flag.
REQ-035 Target size: 120-400 lines of RTL.

Verification
REQ-036 Defaults; 14 bursts; tof 500 in every period -> 7 records, angles -30..30 step 10, each hit with range 500; sweep_done at angle 30; beam_angle_out back to -30.
REQ-037 Dwell at 0 with tofs 900 and 400 -> rec_range_out 400; no tof at 10 -> hit 0, range 0xFFFF.
REQ-038 Sweep with hits 700 at -20 and 700 at 20, others 800 -> nearest_angle -20, nearest_range 700, nearest_valid 1; a sweep with no tofs -> nearest_valid 0.
REQ-039 hold_in high across the COMMIT at -10 -> record emitted, next dwell still at -10, no sweep_done.
REQ-040 tof_valid_in coincident with burst_start_in -> credited to the closing period; two tofs in one period -> only the first is used.
REQ-041 rst_in low mid-dwell at angle 20 -> beam_angle_out -30 immediately, state IDLE, no rec_valid_out pulse.
